// File: rtl/packet_demux.sv
// Receive-side framing demux: strips STP/SDP/END/EDB framing and fillers,
// steering TLP and DLLP payload bytes to separate registered outputs.
module packet_demux #(
  parameter int MAX_TLP_LEN = 1032,
  parameter int DLLP_LEN    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_k,
  input  logic        in_valid,
  output logic [7:0]  tlp_data,
  output logic        tlp_valid,
  output logic        tlp_sop,
  output logic        tlp_eop,
  output logic        tlp_nullified,
  output logic [7:0]  dllp_data,
  output logic        dllp_valid,
  output logic        dllp_sop,
  output logic        dllp_eop,
  output logic        dllp_bad,
  output logic        err_framing,
  output logic [15:0] tlp_good_cnt
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [10:0] MAX_C  = 11'(MAX_TLP_LEN);
  localparam logic [10:0] DLLP_C = 11'(DLLP_LEN);

  typedef enum logic [1:0] {IDLE, TLP, DLLP} state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        first_q, first_d;

  logic [7:0]  tlp_data_q, tlp_data_d;
  logic        tlp_valid_q, tlp_valid_d;
  logic        tlp_sop_q, tlp_sop_d;
  logic        tlp_eop_q, tlp_eop_d;
  logic        tlp_null_q, tlp_null_d;
  logic [7:0]  dllp_data_q, dllp_data_d;
  logic        dllp_valid_q, dllp_valid_d;
  logic        dllp_sop_q, dllp_sop_d;
  logic        dllp_eop_q, dllp_eop_d;
  logic        dllp_bad_q, dllp_bad_d;
  logic        err_q, err_d;
  logic [15:0] good_q, good_d;

  logic        em, eop, bad, term;
  logic        go_tlp, go_dllp;
  logic [10:0] lim;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    first_d      = first_q;
    tlp_data_d   = tlp_data_q;
    tlp_valid_d  = 1'b0;
    tlp_sop_d    = 1'b0;
    tlp_eop_d    = 1'b0;
    tlp_null_d   = 1'b0;
    dllp_data_d  = dllp_data_q;
    dllp_valid_d = 1'b0;
    dllp_sop_d   = 1'b0;
    dllp_eop_d   = 1'b0;
    dllp_bad_d   = 1'b0;
    err_d        = 1'b0;
    good_d       = good_q;
    em           = 1'b0;
    eop          = 1'b0;
    bad          = 1'b0;
    term         = 1'b0;
    go_tlp       = 1'b0;
    go_dllp      = 1'b0;
    lim          = (state_q == TLP) ? MAX_C : DLLP_C;

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!in_k) err_d = 1'b1;
          else if (in_byte == K_STP) go_tlp = 1'b1;
          else if (in_byte == K_SDP) go_dllp = 1'b1;
        end
        TLP, DLLP: begin
          if (!in_k) begin
            if (cnt_q < lim) begin
              em         = hold_vld_q;
              hold_d     = in_byte;
              hold_vld_d = 1'b1;
              cnt_d      = cnt_q + 11'd1;
            end else begin
              term  = 1'b1;
              bad   = 1'b1;
              err_d = 1'b1;
            end
          end else begin
            term = 1'b1;
            if (in_byte == K_END) begin
              if (state_q == TLP) begin
                err_d = (cnt_q == 11'd0);
                if (cnt_q != 11'd0) good_d = good_q + 16'd1;
              end else begin
                bad   = (cnt_q != DLLP_C);
                err_d = (cnt_q != DLLP_C);
              end
            end else if (in_byte == K_EDB) begin
              bad   = 1'b1;
              err_d = (state_q == DLLP);
            end else begin
              bad     = 1'b1;
              err_d   = 1'b1;
              go_tlp  = (in_byte == K_STP);
              go_dllp = (in_byte == K_SDP);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (term) begin
      em         = hold_vld_q;
      eop        = 1'b1;
      hold_vld_d = 1'b0;
      cnt_d      = 11'd0;
      state_d    = IDLE;
    end

    if (em) begin
      first_d = 1'b0;
      if (state_q == TLP) begin
        tlp_valid_d = 1'b1;
        tlp_data_d  = hold_q;
        tlp_sop_d   = first_q;
        tlp_eop_d   = eop;
        tlp_null_d  = eop & bad;
      end else begin
        dllp_valid_d = 1'b1;
        dllp_data_d  = hold_q;
        dllp_sop_d   = first_q;
        dllp_eop_d   = eop;
        dllp_bad_d   = eop & bad;
      end
    end

    // A start symbol opens a fresh packet, even when it aborted one.
    if (go_tlp || go_dllp) begin
      state_d    = go_tlp ? TLP : DLLP;
      cnt_d      = 11'd0;
      hold_vld_d = 1'b0;
      first_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      first_q      <= 1'b0;
      tlp_data_q   <= '0;
      tlp_valid_q  <= 1'b0;
      tlp_sop_q    <= 1'b0;
      tlp_eop_q    <= 1'b0;
      tlp_null_q   <= 1'b0;
      dllp_data_q  <= '0;
      dllp_valid_q <= 1'b0;
      dllp_sop_q   <= 1'b0;
      dllp_eop_q   <= 1'b0;
      dllp_bad_q   <= 1'b0;
      err_q        <= 1'b0;
      good_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      first_q      <= first_d;
      tlp_data_q   <= tlp_data_d;
      tlp_valid_q  <= tlp_valid_d;
      tlp_sop_q    <= tlp_sop_d;
      tlp_eop_q    <= tlp_eop_d;
      tlp_null_q   <= tlp_null_d;
      dllp_data_q  <= dllp_data_d;
      dllp_valid_q <= dllp_valid_d;
      dllp_sop_q   <= dllp_sop_d;
      dllp_eop_q   <= dllp_eop_d;
      dllp_bad_q   <= dllp_bad_d;
      err_q        <= err_d;
      good_q       <= good_d;
    end
  end

  assign tlp_data      = tlp_data_q;
  assign tlp_valid     = tlp_valid_q;
  assign tlp_sop       = tlp_sop_q;
  assign tlp_eop       = tlp_eop_q;
  assign tlp_nullified = tlp_null_q;
  assign dllp_data     = dllp_data_q;
  assign dllp_valid    = dllp_valid_q;
  assign dllp_sop      = dllp_sop_q;
  assign dllp_eop      = dllp_eop_q;
  assign dllp_bad      = dllp_bad_q;
  assign err_framing   = err_q;
  assign tlp_good_cnt  = good_q;

endmodule

// File: tb/tb_packet_demux.sv
// Directed bench for packet_demux: records emitted bytes per output
// and compares them with hand-computed expectations.
module tb_packet_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_k;
  logic        in_valid;
  logic [7:0]  tlp_data;
  logic        tlp_valid, tlp_sop, tlp_eop, tlp_nullified;
  logic [7:0]  dllp_data;
  logic        dllp_valid, dllp_sop, dllp_eop, dllp_bad;
  logic        err_framing;
  logic [15:0] tlp_good_cnt;

  packet_demux dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_k(in_k), .in_valid(in_valid),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid),
    .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
    .tlp_nullified(tlp_nullified),
    .dllp_data(dllp_data), .dllp_valid(dllp_valid),
    .dllp_sop(dllp_sop), .dllp_eop(dllp_eop),
    .dllp_bad(dllp_bad),
    .err_framing(err_framing),
    .tlp_good_cnt(tlp_good_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err   = 0;
  int n_both  = 0;
  logic [10:0] tq[$];
  logic [10:0] dq[$];

  always @(negedge clk) begin
    if (tlp_valid)
      tq.push_back({tlp_data, tlp_sop, tlp_eop, tlp_nullified});
    if (dllp_valid)
      dq.push_back({dllp_data, dllp_sop, dllp_eop, dllp_bad});
    if (err_framing) n_err++;
    if (tlp_valid && dllp_valid) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sym(input logic k, input logic [7:0] b);
    @(negedge clk);
    in_k = k; in_byte = b; in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_k = 1'b0; in_byte = 8'h00;
    end
  endtask

  task automatic clr();
    tq.delete(); dq.delete(); n_err = 0;
  endtask

  task automatic chk_tq(input string tag, input int idx,
                        input logic [10:0] exp);
    if (idx < tq.size()) chk(tag, 32'(tq[idx]), 32'(exp));
    else chk(tag, 32'h7FF, 32'(exp));
  endtask

  task automatic chk_dq(input string tag, input int idx,
                        input logic [10:0] exp);
    if (idx < dq.size()) chk(tag, 32'(dq[idx]), 32'(exp));
    else chk(tag, 32'h7FF, 32'(exp));
  endtask

  localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, SKP = 8'h1C;
  localparam logic [7:0] STP = 8'hFB, SDP = 8'h5C, ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE, IDL = 8'h7C;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_k = 1'b0; in_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tlp_valid), 0);
    chk("rst_dvalid", 32'(dllp_valid), 0);
    chk("rst_err", 32'(err_framing), 0);
    chk("rst_cnt", 32'(tlp_good_cnt), 0);
    reset = 1'b0;
    clr();

    // basic TLP
    sym(1, STP); sym(0, 8'hFF); sym(0, 8'hFF); sym(1, ENDK);
    idle(3);
    chk("t1_n", tq.size(), 2);
    chk_tq("t1_b0", 0, {8'hFF, 3'b100});
    chk_tq("t1_b1", 1, {8'hFF, 3'b010});
    chk("t1_err", n_err, 0);
    chk("t1_good", 32'(tlp_good_cnt), 1);
    clr();

    // good DLLP
    sym(1, SDP);
    for (int i = 0; i < 6; i++) sym(0, 8'(i));
    sym(1, ENDK); idle(3);
    chk("d1_n", dq.size(), 6);
    chk_dq("d1_b0", 0, {8'h00, 3'b100});
    chk_dq("d1_b3", 3, {8'h03, 3'b000});
    chk_dq("d1_b5", 5, {8'h05, 3'b010});
    chk("d1_err", n_err, 0);
    clr();

    // short DLLP
    sym(1, SDP);
    for (int i = 0; i < 5; i++) sym(0, 8'(i));
    sym(1, ENDK); idle(3);
    chk("d2_n", dq.size(), 5);
    chk_dq("d2_b4", 4, {8'h04, 3'b011});
    chk("d2_err", n_err, 1);
    chk("d2_tq", tq.size(), 0);
    clr();

    // EDB nullify, then empty TLP
    sym(1, STP); sym(0, 8'hAA); sym(0, 8'hBB); sym(1, EDB);
    idle(2);
    chk("e1_n", tq.size(), 2);
    chk_tq("e1_b0", 0, {8'hAA, 3'b100});
    chk_tq("e1_b1", 1, {8'hBB, 3'b011});
    chk("e1_err", n_err, 0);
    clr();
    sym(1, STP); sym(1, ENDK); idle(2);
    chk("e2_n", tq.size(), 0);
    chk("e2_err", n_err, 1);
    chk("e2_good", 32'(tlp_good_cnt), 1);
    clr();

    // STP aborted by SDP, then stray data byte
    sym(1, STP); sym(0, 8'h11); sym(0, 8'h22); sym(1, SDP);
    for (int i = 1; i <= 6; i++) sym(0, 8'(i));
    sym(1, ENDK); idle(2);
    chk("a1_tn", tq.size(), 2);
    chk_tq("a1_t0", 0, {8'h11, 3'b100});
    chk_tq("a1_t1", 1, {8'h22, 3'b011});
    chk("a1_dn", dq.size(), 6);
    chk_dq("a1_d0", 0, {8'h01, 3'b100});
    chk_dq("a1_d5", 5, {8'h06, 3'b010});
    chk("a1_err", n_err, 1);
    clr();
    sym(0, 8'h33); idle(2);
    chk("a2_err", n_err, 1);
    chk("a2_out", tq.size() + dq.size(), 0);
    clr();

    // fillers and bubbles
    sym(1, COM); sym(1, SKP); sym(1, SKP); sym(1, IDL); sym(1, PAD);
    sym(1, STP); sym(0, 8'h01); idle(1); sym(0, 8'h02); idle(2);
    sym(0, 8'h03); sym(1, ENDK); idle(3);
    chk("f1_n", tq.size(), 3);
    chk_tq("f1_b0", 0, {8'h01, 3'b100});
    chk_tq("f1_b1", 1, {8'h02, 3'b000});
    chk_tq("f1_b2", 2, {8'h03, 3'b010});
    chk("f1_err", n_err, 0);
    chk("f1_good", 32'(tlp_good_cnt), 2);
    clr();

    // overlong TLP
    sym(1, STP);
    for (int i = 1; i <= 1033; i++) sym(0, 8'(i));
    idle(3);
    chk("o1_n", tq.size(), 1032);
    chk_tq("o1_first", 0, {8'h01, 3'b100});
    chk_tq("o1_mid", 500, {8'hF5, 3'b000});
    chk_tq("o1_last", 1031, {8'h08, 3'b011});
    chk("o1_err", n_err, 1);
    chk("o1_good", 32'(tlp_good_cnt), 2);
    clr();

    // reset mid-packet
    sym(1, STP); sym(0, 8'h01); sym(0, 8'h02);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("r1_tvalid", 32'(tlp_valid), 0);
    chk("r1_eop", 32'(tlp_eop), 0);
    chk("r1_good", 32'(tlp_good_cnt), 0);
    reset = 1'b0;
    clr();
    sym(1, ENDK); sym(1, SKP); idle(3);
    chk("r2_out", tq.size() + dq.size(), 0);
    chk("r2_err", n_err, 0);
    chk("r2_good", 32'(tlp_good_cnt), 0);
    chk("both_valid", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
